uart_tx_engine_param: RTL
=========================

Name: uart_tx_engine_param

Overview:
- Parametrised UART transmit engine for the APB UART subsystem. It replaces the fixed 7/8-bit transmitter with fixed parity.
- Integrates a transmit FIFO of configurable depth.
- Supports a run-time character length of 5..DATA_W bits, five parity modes and 1 or 2 stop bits.
- Frame timing comes from an external one-clk-wide baud_pulse, one pulse per bit period, produced by the existing baud generator.

Parameters:
- DATA_W, 8, maximum character width; legal range 5..9.
- FIFO_DEPTH, 16, transmit FIFO entries; power of 2, minimum 2.
- ADDR_W, 4, log2(FIFO_DEPTH); must be set consistently with FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- baud_pulse  in  1  one-clk strobe, one per bit period.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  DATA_W  character; LSB is sent first; bits at and above char_len are ignored.
- char_len  in  4  data bits per frame, 5..DATA_W; values outside the range are clamped to the nearest limit.
- parity_mode  in  3  0 none, 1 odd, 2 even, 3 mark, 4 space; values 5-7 mean none.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- break_req  in  1  level request to hold the line low (optional feature).
- tx  out  1  serial line.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- fifo_level  out  ADDR_W+1  current FIFO occupancy.
- overflow  out  1  one-clk pulse when a write is dropped.
- tx_busy  out  1  state machine is not in IDLE.
- tx_empty  out  1  fifo_empty and not tx_busy (transmitter fully drained).

Behaviour:
- Reset values:
  - tx = 1, tx_busy = 0, overflow = 0.
  - fifo_empty = 1, fifo_full = 0, fifo_level = 0, tx_empty = 1.
  - State = IDLE; FIFO pointers = 0.
- Reset asserted mid-frame aborts the frame immediately, drives tx to 1 and discards FIFO contents.
- FIFO:
  - Synchronous write. Read and write pointers are ADDR_W+1 bits; full/empty come from pointer comparison. Pointers wrap naturally at 2*FIFO_DEPTH.
  - fifo_full is evaluated before any pop in the same cycle. A wr_en while fifo_full is dropped and pulses overflow one cycle later, even if a pop occurs that cycle.
  - A simultaneous push and pop on a non-full FIFO leaves fifo_level unchanged.
  - Status outputs are registered and update the cycle after the push or pop.
- Per-frame latch: char_len, parity_mode and stop2 are latched at the pop. Changes during a frame take effect only on the next frame.
- Parity bit values: odd = ~^data, even = ^data, mark = 1, space = 0. Parity covers the char_len data bits only.
- tx is registered and changes only on baud_pulse edges, except when reset forces it to 1.
- State machine:
  - IDLE (tx = 1), evaluated every clk:
    - If break is enabled and break_req = 1, go to BREAK_ARM.
    - Else if FIFO is not empty, pop the shift register, latch config and go to ARMED.
    - break_req takes priority over FIFO data.
  - ARMED: on baud_pulse, tx <= 0 and go to START.
  - START: on baud_pulse, tx <= bit0, bit_cnt = 1, go to DATA.
  - DATA: on baud_pulse:
    - If bit_cnt < len, tx <= bit[bit_cnt] and bit_cnt++.
    - Else, if parity is enabled, tx <= parity and go to PARITY; otherwise tx <= 1 and go to STOP with stop_cnt = 0.
  - PARITY: on baud_pulse, tx <= 1 and go to STOP.
  - STOP: on baud_pulse:
    - If stop2 and stop_cnt = 0, set stop_cnt = 1 and stay.
    - Else, if FIFO is not empty and there is no break request, pop, latch, tx <= 0 and go to START. This gives back-to-back frames with no idle gap.
    - Else, tx stays 1 and the machine goes to IDLE.
- Latency: a write into an empty idle FIFO causes the pop 2 clks later. tx falls on the first baud_pulse after the pop.
- A baud_pulse arriving in IDLE, or in the same cycle as a pop, does not advance the frame.
- break_req asserted mid-frame is held off until the frame completes.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - IDLE or STOP exit with break_req = 1 goes to BREAK_ARM.
  - BREAK_ARM: on baud_pulse, tx <= 0 and go to BREAK.
  - BREAK: tx is held at 0 while break_req = 1. After break_req deasserts, the next baud_pulse sets tx <= 1 and enters STOP. This guarantees one stop period, or two if stop2 is set.
  - tx_busy = 1 throughout the break.
- Undefined: the break_req port is present but ignored; the BREAK states are not synthesised.

Test Plan:
- Reset, then write 0x55 with char_len = 8, parity none, stop2 = 0, baud_pulse every 16 clks -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 clks wide; tx_busy then deasserts and tx_empty = 1.
- Write 0x13 with char_len = 7, parity_mode = 1 (odd) -> data bits 1,1,0,0,1,0,0 LSB first, parity = 0, stop = 1; check a second frame with parity_mode = 2 gives parity = 1.
- Write 17 words with FIFO_DEPTH = 16 while no baud_pulse occurs -> the first pop leaves 15 entries; the 17th write is accepted; an 18th write pulses overflow for one clk and fifo_level stays at 16.
- Back-to-back 0xA5 and 0x3C with stop2 = 1 -> two stop-bit periods of 1, then the next start bit immediately with no extra idle period; fifo_empty = 1 after the second pop.
- Change char_len 8->5 mid-frame of 0xFF -> the current frame still sends 8 data bits; the next frame of 0xFF sends 5 ones.
- UART_TX_BREAK_EN: assert break_req mid-frame -> the frame completes; tx is then 0 for the duration of break_req; tx returns to 1 on the first baud_pulse after release and a queued byte starts after one stop period. Assert reset_n = 0 mid-break -> tx = 1 asynchronously.

Source files
------------

// File: rtl/uart_tx_engine_param.sv
// UART transmit engine: TX FIFO, 5..DATA_W bit characters, five parity modes, 1/2 stop bits.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_engine_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_pulse,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        char_len,
  input  logic [2:0]        parity_mode,
  input  logic              stop2,
  input  logic              break_req,
  output logic              tx,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic              tx_busy,
  output logic              tx_empty
);

  typedef logic [ADDR_W:0] ptr_t;

  localparam logic [3:0] MinLen = 4'd5;
  localparam logic [3:0] MaxLen = 4'(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StStart,
    StData,
    StParity,
    StStop
`ifdef UART_TX_BREAK_EN
    ,
    StBreakArm,
    StBreak
`endif
  } state_e;

  // FIFO storage and status
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;
  logic [DATA_W-1:0] rd_data;

  // Frame state
  state_e            state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [3:0]        len_q, len_d;
  logic              par_en_q, par_en_d;
  logic              par_val_q, par_val_d;
  logic              stop2_q, stop2_d;
  logic              busy_q, busy_d;
  logic              tx_empty_q, tx_empty_d;

  // Decoded configuration for the character at the FIFO head
  logic [3:0]        len_clamped;
  logic [DATA_W-1:0] masked;
  logic              par_en_new, par_val_new;

`ifndef UART_TX_BREAK_EN
  logic unused_break_req;
  assign unused_break_req = break_req;
`endif

  assign rd_data = fifo_mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    len_clamped = char_len;
    if (char_len < MinLen) begin
      len_clamped = MinLen;
    end else if (char_len > MaxLen) begin
      len_clamped = MaxLen;
    end
    masked = '0;
    for (int i = 0; i < DATA_W; i++) begin
      masked[i] = rd_data[i] & (4'(i) < len_clamped);
    end
    par_en_new  = 1'b0;
    par_val_new = 1'b0;
    case (parity_mode)
      3'd1:    begin par_en_new = 1'b1; par_val_new = ~^masked; end
      3'd2:    begin par_en_new = 1'b1; par_val_new = ^masked;  end
      3'd3:    begin par_en_new = 1'b1; par_val_new = 1'b1;     end
      3'd4:    begin par_en_new = 1'b1; par_val_new = 1'b0;     end
      default: begin par_en_new = 1'b0; par_val_new = 1'b0;     end
    endcase
  end

  // Full is judged on the registered flag, so a write while full is dropped even if a pop
  // frees a slot in the same cycle.
  always_comb begin
    push     = wr_en & ~full_q;
    ovf_d    = wr_en & full_q;
    wr_ptr_d = wr_ptr_q + ptr_t'(push);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (level_d == ptr_t'(FIFO_DEPTH));
    empty_d  = (level_d == '0);
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_val_d  = par_val_q;
    stop2_d    = stop2_q;
    pop        = 1'b0;

    case (state_q)
      StIdle: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d = StBreakArm;
          stop2_d = stop2;
        end else
`endif
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (baud_pulse) begin
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_pulse) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd1;
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_pulse) begin
          if (bit_cnt_q < len_q) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (par_en_q) begin
            tx_d    = par_val_q;
            state_d = StParity;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = StStop;
          end
        end
      end
      StParity: begin
        if (baud_pulse) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (baud_pulse) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state_d = StBreakArm;
            stop2_d = stop2;
          end else
`endif
          if (!empty_q) begin
            // Next start bit goes out on this very pulse: no idle gap between frames
            pop     = 1'b1;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      StBreakArm: begin
        if (baud_pulse) begin
          tx_d    = 1'b0;
          state_d = StBreak;
        end
      end
      StBreak: begin
        if (baud_pulse && !break_req) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
`endif
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase

    if (pop) begin
      shift_d    = masked;
      len_d      = len_clamped;
      par_en_d   = par_en_new;
      par_val_d  = par_val_new;
      stop2_d    = stop2;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
    end
  end

  assign busy_d     = (state_d != StIdle);
  assign tx_empty_d = empty_d & (state_d == StIdle);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      len_q      <= MaxLen;
      par_en_q   <= 1'b0;
      par_val_q  <= 1'b0;
      stop2_q    <= 1'b0;
      busy_q     <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_val_q  <= par_val_d;
      stop2_q    <= stop2_d;
      busy_q     <= busy_d;
      tx_empty_q <= tx_empty_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign tx_busy    = busy_q;
  assign tx_empty   = tx_empty_q;

endmodule
